// File: rtl/memory_game_sequence_player_if.sv
// memory_game_sequence_player_if: game-FSM/register-file/display bundle for the sequence player.
// Ports: start/abort/seq_len/delay requests, rd_addr/rd_data synchronous register-file read,
// uo_out segments {dp,g,f,e,d,c,b,a}, busy/done status. master drives requests, slave is the player.
interface memory_game_sequence_player_if #(parameter int MAX_LEN = 16);
  localparam int AW = $clog2(MAX_LEN);
  logic          start;
  logic          abort;
  logic [4:0]    seq_len;
  logic [4:0]    delay;
  logic [AW-1:0] rd_addr;
  logic [2:0]    rd_data;
  logic [7:0]    uo_out;
  logic          busy;
  logic          done;
  modport master(output start, abort, seq_len, delay, rd_data, input rd_addr, uo_out, busy, done);
  modport slave(input start, abort, seq_len, delay, rd_data, output rd_addr, uo_out, busy, done);
endinterface

// File: rtl/memory_game_sequence_player.sv
// memory_game_sequence_player: flashes a stored digit sequence on a seven-segment display.
// Ports: clk, rst (async, active-high), bus (slave): start/abort/seq_len/delay in,
// rd_addr out / rd_data in (one-cycle synchronous read), uo_out registered segments, busy, done pulse.
module memory_game_sequence_player #(
  parameter int MAX_LEN  = 16,
  parameter int TICK_DIV = 12_000_000
) (
  input logic clk,
  input logic rst,
  memory_game_sequence_player_if.slave bus
);
  localparam int AW = $clog2(MAX_LEN);
  localparam int LW = AW + 1;
  localparam int OW = $clog2(32 * TICK_DIV + 1);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] SHOW  = 3'd2;
  localparam logic [2:0] GAP   = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  logic [2:0]    state_q, state_d;
  logic [AW-1:0] index_q, index_d;
  logic [OW-1:0] timer_q, timer_d;
  logic [OW-1:0] on_q, on_d;
  logic [LW-1:0] len_q, len_d;
  logic [2:0]    digit_q, digit_d;
  logic          first_q, first_d;
  logic [7:0]    uo_q, uo_d;
  logic          done_q, done_d;
  function automatic logic [6:0] seg(input logic [2:0] d);
    case (d)
      3'd0: seg = 7'h3F;
      3'd1: seg = 7'h06;
      3'd2: seg = 7'h5B;
      3'd3: seg = 7'h4F;
      3'd4: seg = 7'h66;
      3'd5: seg = 7'h6D;
      3'd6: seg = 7'h7D;
      default: seg = 7'h07;
    endcase
  endfunction
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    timer_d = timer_q;
    on_d    = on_q;
    len_d   = len_q;
    digit_d = digit_q;
    first_d = 1'b0;
    uo_d    = 8'h00;
    done_d  = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
      index_d = '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          len_d   = (32'(bus.seq_len) > MAX_LEN) ? LW'(MAX_LEN) : LW'(bus.seq_len);
          on_d    = OW'((32'(bus.delay) + 32'd1) * 32'(TICK_DIV));
          index_d = '0;
          state_d = (len_d == '0) ? DONE : FETCH;
        end
        FETCH: begin
          state_d = SHOW;
          timer_d = on_q - OW'(1);
          first_d = 1'b1;
        end
        SHOW: begin
          digit_d = first_q ? bus.rd_data : digit_q;
          uo_d    = {index_q == '0, seg(digit_d)};
          timer_d = (timer_q == '0) ? on_q - OW'(1) : timer_q - OW'(1);
          state_d = (timer_q == '0) ? GAP : SHOW;
        end
        GAP: begin
          timer_d = timer_q - OW'(1);
          if (timer_q == '0) begin
            state_d = ({1'b0, index_q} == len_q - LW'(1)) ? DONE : FETCH;
            index_d = ({1'b0, index_q} == len_q - LW'(1)) ? index_q : index_q + AW'(1);
          end
        end
        DONE: begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      index_q <= '0;
      timer_q <= '0;
      on_q    <= '0;
      len_q   <= '0;
      digit_q <= '0;
      first_q <= 1'b0;
      uo_q    <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      timer_q <= timer_d;
      on_q    <= on_d;
      len_q   <= len_d;
      digit_q <= digit_d;
      first_q <= first_d;
      uo_q    <= uo_d;
      done_q  <= done_d;
    end
  end
  assign bus.rd_addr = index_q;
  assign bus.uo_out  = uo_q;
  assign bus.busy    = state_q != IDLE;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_memory_game_sequence_player.sv
// tb_memory_game_sequence_player: directed table and corner-case sequences for the sequence player.
module tb_memory_game_sequence_player;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  memory_game_sequence_player_if #(.MAX_LEN(16)) bus();
  memory_game_sequence_player #(.MAX_LEN(16), .TICK_DIV(1)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  logic [2:0] mem [16];
  always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];
  logic [6:0] segt [8] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};
  typedef struct {
    logic       start;
    logic       abort;
    logic [4:0] len;
    logic [4:0] dly;
    logic [7:0] uo;
    logic       busy;
    logic       done;
    logic       ca;
  } vec_t;
  vec_t tbl[$];
  int pass = 0;
  int total = 0;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic void add(input logic s, input logic a, input int l, input int d,
                              input int uo, input logic b, input logic dn, input logic ca, input int n);
    vec_t v;
    v.start = s; v.abort = a; v.len = 5'(l); v.dly = 5'(d);
    v.uo = 8'(uo); v.busy = b; v.done = dn; v.ca = ca;
    repeat (n) tbl.push_back(v);
  endfunction
  task automatic go(input int l, input int d);
    bus.seq_len = 5'(l);
    bus.delay = 5'(d);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask
  initial begin
    int cyc, n, run, dones;
    logic got;
    logic [7:0] prev;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.seq_len = '0;
    bus.delay = '0;
    for (int i = 0; i < 16; i++) mem[i] = 3'(i * 3);
    mem[0] = 3'd5; mem[1] = 3'd0; mem[2] = 3'd7;
    #3;
    chk("reset uo", int'(bus.uo_out), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    chk("reset addr", int'(bus.rd_addr), 0);
    step();
    rst = 1'b0;
    step();
    add(1, 0, 0, 3, 8'h00, 1, 0, 1, 1);
    add(0, 0, 0, 3, 8'h00, 0, 1, 1, 1);
    add(0, 0, 0, 3, 8'h00, 0, 0, 1, 1);
    add(1, 1, 3, 2, 8'h00, 0, 0, 1, 1);
    add(0, 0, 3, 2, 8'h00, 0, 0, 1, 1);
    add(0, 1, 3, 2, 8'h00, 0, 0, 1, 1);
    add(1, 0, 3, 2, 8'h00, 1, 0, 0, 1);
    add(0, 0, 9, 0, 8'h00, 1, 0, 0, 1);
    add(0, 0, 9, 0, 8'hED, 1, 0, 0, 3);
    add(0, 0, 9, 0, 8'h00, 1, 0, 0, 4);
    add(0, 0, 9, 0, 8'h3F, 1, 0, 0, 1);
    add(1, 0, 1, 0, 8'h3F, 1, 0, 0, 1);
    add(0, 0, 9, 0, 8'h3F, 1, 0, 0, 1);
    add(0, 0, 9, 0, 8'h00, 1, 0, 0, 4);
    add(0, 0, 9, 0, 8'h07, 1, 0, 0, 3);
    add(0, 0, 9, 0, 8'h00, 1, 0, 0, 3);
    add(0, 0, 9, 0, 8'h00, 0, 1, 0, 1);
    add(0, 0, 9, 0, 8'h00, 0, 0, 0, 1);
    foreach (tbl[i]) begin
      bus.start = tbl[i].start;
      bus.abort = tbl[i].abort;
      bus.seq_len = tbl[i].len;
      bus.delay = tbl[i].dly;
      step();
      chk($sformatf("row%0d uo", i), int'(bus.uo_out), int'(tbl[i].uo));
      chk($sformatf("row%0d busy", i), int'(bus.busy), int'(tbl[i].busy));
      chk($sformatf("row%0d done", i), int'(bus.done), int'(tbl[i].done));
      if (tbl[i].ca) chk($sformatf("row%0d addr", i), int'(bus.rd_addr), 0);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 3'(i * 3);
    go(31, 31);
    cyc = 0; n = 0; run = 0; got = 1'b0; prev = 8'h00;
    while (!got && cyc < 3000) begin
      step();
      cyc++;
      if (bus.uo_out != 8'h00) begin
        if (prev == 8'h00) begin
          chk($sformatf("clamp addr%0d", n), int'(bus.rd_addr), n);
          chk($sformatf("clamp seg%0d", n), int'(bus.uo_out), int'({n == 0, segt[mem[n]]}));
          run = 0;
        end
        run++;
      end else if (prev != 8'h00) begin
        chk($sformatf("clamp on-time%0d", n), run, 32);
        n++;
      end
      if (bus.done) got = 1'b1;
      prev = bus.uo_out;
    end
    chk("clamp done seen", int'(got), 1);
    chk("clamp done cycle", cyc, 1041);
    chk("clamp digits", n, 16);
    mem[0] = 3'd5; mem[1] = 3'd0; mem[2] = 3'd7;
    step();
    go(3, 2);
    repeat (9) step();
    chk("abort pre uo", int'(bus.uo_out), 8'h3F);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort uo", int'(bus.uo_out), 0);
    chk("abort busy", int'(bus.busy), 0);
    dones = 0;
    repeat (30) begin
      step();
      if (bus.done || bus.busy) dones++;
    end
    chk("abort no done", dones, 0);
    go(3, 2);
    step();
    step();
    chk("replay uo", int'(bus.uo_out), 8'hED);
    chk("replay addr", int'(bus.rd_addr), 0);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    go(3, 2);
    repeat (4) step();
    chk("gap pre uo", int'(bus.uo_out), 8'hED);
    #2 rst = 1'b1;
    #1;
    chk("rst uo", int'(bus.uo_out), 0);
    chk("rst busy", int'(bus.busy), 0);
    chk("rst addr", int'(bus.rd_addr), 0);
    step();
    rst = 1'b0;
    dones = 0;
    repeat (12) begin
      step();
      if (bus.busy || bus.done || bus.uo_out != 8'h00) dones++;
    end
    chk("post rst idle", dones, 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
